countdown_timer: RTL and testbench

Countdown counterpart to the stopwatch timer: loads a preset, counts down once per clk while running, and flags expiry at zero. Start and stop are rising-edge detected internally, in the same style as the stopwatch, so both blocks share one button/strobe front end. Sits beside the stopwatch in the timer subsystem and drives alarm/timeout logic through done and expired.

---
 rtl/countdown_if.sv | 36 +++
 rtl/countdown_timer.sv | 102 ++++++++++
 tb/tb_countdown_timer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/countdown_if.sv
// Handshake bundle between the timer front end and countdown_timer.
// The DUT uses the slave modport; the controlling logic uses master.
interface countdown_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  load;
    logic [DATA_WIDTH-1:0] load_value;
    logic                  start;
    logic                  stop;
    logic [DATA_WIDTH-1:0] count;
    logic                  running;
    logic                  done;
    logic                  expired;

    modport master (
        output load,
        output load_value,
        output start,
        output stop,
        input  count,
        input  running,
        input  done,
        input  expired
    );

    modport slave (
        input  load,
        input  load_value,
        input  start,
        input  stop,
        output count,
        output running,
        output done,
        output expired
    );
endinterface

// File: rtl/countdown_timer.sv
// Presettable down-counter with edge-detected start/stop and a one-cycle done pulse.
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN to reload the preset at zero instead of expiring.
module countdown_timer #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX        = 99
) (
    input logic        clk,
    input logic        reset,
    countdown_if.slave bus
);
    localparam logic [DATA_WIDTH-1:0] MAX_V = DATA_WIDTH'(MAX);
    localparam logic [DATA_WIDTH-1:0] ONE   = DATA_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        PAUSED,
        EXPIRED
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] reload_q, reload_d;
    logic                  done_q, done_d;
    logic                  start_z, stop_z;
    logic                  start_edge, stop_edge;
    logic                  step;
    logic [DATA_WIDTH-1:0] clamped;

    assign start_edge = bus.start & ~start_z;
    assign stop_edge  = bus.stop  & ~stop_z;
    assign clamped    = (bus.load_value > MAX_V) ? MAX_V : bus.load_value;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
            start_z  <= 1'b0;
            stop_z   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            start_z  <= bus.start;
            stop_z   <= bus.stop;
        end
    end

    // A start edge from IDLE/PAUSED counts as the first decrement, so a preset of N reaches done N cycles later.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        step     = 1'b0;

        if (bus.load) begin
            count_d  = clamped;
            reload_d = clamped;
            state_d  = IDLE;
        end else begin
            case (state_q)
                RUNNING: begin
                    if (stop_edge) state_d = PAUSED;
                    else           step    = 1'b1;
                end
                IDLE, PAUSED: begin
                    if (!stop_edge && start_edge && (count_q != '0)) step = 1'b1;
                end
                default: ;
            endcase

            if (step) begin
                if (count_q > ONE) begin
                    count_d = count_q - ONE;
                    state_d = RUNNING;
                end else begin
                    done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    count_d = reload_q;
                    state_d = RUNNING;
`else
                    count_d = '0;
                    state_d = EXPIRED;
`endif
                end
            end
        end
    end

    assign bus.count   = count_q;
    assign bus.running = (state_q == RUNNING);
    assign bus.done    = done_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    assign bus.expired = 1'b0;
`else
    assign bus.expired = (state_q == EXPIRED);
`endif
endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer; expectations follow the one-shot or
// auto-reload behaviour depending on COUNTDOWN_AUTO_RELOAD_EN.
module tb_countdown_timer;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    countdown_if #(.DATA_WIDTH(16)) bus ();

    countdown_timer #(.DATA_WIDTH(16), .MAX(99)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Inputs change 1 time unit after the edge and outputs are sampled at the same point.
    task automatic applyStimulus(input logic ld, input logic [15:0] val, input logic st, input logic sp);
        bus.load       = ld;
        bus.load_value = val;
        bus.start      = st;
        bus.stop       = sp;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0);
        checkOutput("rst_count",   32'(bus.count),   0);
        checkOutput("rst_running", 32'(bus.running), 0);
        checkOutput("rst_done",    32'(bus.done),    0);
        checkOutput("rst_expired", 32'(bus.expired), 0);
        reset = 1'b0;

        applyStimulus(1'b1, 16'd3, 1'b0, 1'b0);
        checkOutput("t1_load", 32'(bus.count), 3);
        applyStimulus(1'b0, 16'd3, 1'b1, 1'b0);
        checkOutput("t1_c2", 32'(bus.count), 2);
        checkOutput("t1_run", 32'(bus.running), 1);
        applyStimulus(1'b0, 16'd3, 1'b0, 1'b0);
        checkOutput("t1_c1", 32'(bus.count), 1);
        checkOutput("t1_nodone", 32'(bus.done), 0);
        applyStimulus(1'b0, 16'd3, 1'b0, 1'b0);
        checkOutput("t1_c0", 32'(bus.count), AR ? 3 : 0);
        checkOutput("t1_done", 32'(bus.done), 1);
        checkOutput("t1_exp", 32'(bus.expired), AR ? 0 : 1);
        checkOutput("t1_run0", 32'(bus.running), AR ? 1 : 0);
        applyStimulus(1'b0, 16'd3, 1'b0, 1'b0);
        checkOutput("t1_done_clr", 32'(bus.done), 0);
        checkOutput("t1_after", 32'(bus.count), AR ? 2 : 0);
        applyStimulus(1'b0, 16'd3, 1'b1, 1'b0);
        checkOutput("t1_start_ign", 32'(bus.count), AR ? 1 : 0);
        checkOutput("t1_exp_hold", 32'(bus.expired), AR ? 0 : 1);

        applyStimulus(1'b1, 16'd250, 1'b0, 1'b0);
        checkOutput("t2_clamp250", 32'(bus.count), 99);
        checkOutput("t2_idle", 32'(bus.running), 0);
        applyStimulus(1'b1, 16'd100, 1'b0, 1'b0);
        checkOutput("t2_clamp100", 32'(bus.count), 99);
        applyStimulus(1'b1, 16'd99, 1'b0, 1'b0);
        checkOutput("t2_max", 32'(bus.count), 99);
        applyStimulus(1'b1, 16'd0, 1'b0, 1'b0);
        checkOutput("t2_zero", 32'(bus.count), 0);
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
        checkOutput("t2_start0_cnt", 32'(bus.count), 0);
        checkOutput("t2_start0_run", 32'(bus.running), 0);

        applyStimulus(1'b1, 16'd10, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
        checkOutput("t3_c9", 32'(bus.count), 9);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0);
        checkOutput("t3_c7", 32'(bus.count), 7);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);
        checkOutput("t3_stop_cnt", 32'(bus.count), 7);
        checkOutput("t3_stop_run", 32'(bus.running), 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 16'd0, 1'b0, 1'b0);
            checkOutput("t3_hold", 32'(bus.count), 7);
            checkOutput("t3_hold_run", 32'(bus.running), 0);
        end
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
        checkOutput("t3_resume", 32'(bus.count), 6);
        checkOutput("t3_resume_run", 32'(bus.running), 1);
        for (int k = 5; k >= 1; k--) begin
            applyStimulus(1'b0, 16'd0, 1'b0, 1'b0);
            checkOutput("t3_down", 32'(bus.count), 32'(k));
            checkOutput("t3_nodone", 32'(bus.done), 0);
        end
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0);
        checkOutput("t3_end", 32'(bus.count), AR ? 10 : 0);
        checkOutput("t3_done", 32'(bus.done), 1);

        applyStimulus(1'b1, 16'd5, 1'b0, 1'b0);
        checkOutput("t4_load", 32'(bus.count), 5);
        applyStimulus(1'b0, 16'd5, 1'b1, 1'b1);
        checkOutput("t4_both_cnt", 32'(bus.count), 5);
        checkOutput("t4_both_run", 32'(bus.running), 0);
        applyStimulus(1'b0, 16'd5, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 16'd5, 1'b1, 1'b0);
            checkOutput("t4_held", 32'(bus.count), 32'(4 - i));
            checkOutput("t4_held_run", 32'(bus.running), 1);
        end
        applyStimulus(1'b0, 16'd5, 1'b0, 1'b0);
        checkOutput("t4_end", 32'(bus.count), AR ? 5 : 0);
        checkOutput("t4_done", 32'(bus.done), 1);

        applyStimulus(1'b1, 16'd5, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'd5, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'd5, 1'b0, 1'b0);
        checkOutput("t5_c3", 32'(bus.count), 3);
        applyStimulus(1'b1, 16'd8, 1'b0, 1'b0);
        checkOutput("t5_abort_cnt", 32'(bus.count), 8);
        checkOutput("t5_abort_run", 32'(bus.running), 0);
        checkOutput("t5_abort_done", 32'(bus.done), 0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 16'd8, 1'b0, 1'b0);
            checkOutput("t5_idle_cnt", 32'(bus.count), 8);
            checkOutput("t5_idle_done", 32'(bus.done), 0);
        end
        applyStimulus(1'b0, 16'd8, 1'b1, 1'b0);
        checkOutput("t5_c7", 32'(bus.count), 7);
        applyStimulus(1'b0, 16'd8, 1'b0, 1'b0);
        reset = 1'b1;
        applyStimulus(1'b0, 16'd8, 1'b0, 1'b0);
        checkOutput("t5_rst_cnt", 32'(bus.count), 0);
        checkOutput("t5_rst_run", 32'(bus.running), 0);
        reset = 1'b0;

        applyStimulus(1'b1, 16'd1, 1'b0, 1'b0);
        checkOutput("t6_load1", 32'(bus.count), 1);
        applyStimulus(1'b0, 16'd1, 1'b1, 1'b0);
        checkOutput("t6_cnt", 32'(bus.count), AR ? 1 : 0);
        checkOutput("t6_done", 32'(bus.done), 1);
        checkOutput("t6_exp", 32'(bus.expired), AR ? 0 : 1);
        applyStimulus(1'b0, 16'd1, 1'b0, 1'b0);
        checkOutput("t6_done2", 32'(bus.done), AR ? 1 : 0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        applyStimulus(1'b1, 16'd3, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'd3, 1'b1, 1'b0);
        checkOutput("ar_c2", 32'(bus.count), 2);
        applyStimulus(1'b0, 16'd3, 1'b0, 1'b0);
        checkOutput("ar_c1", 32'(bus.count), 1);
        applyStimulus(1'b0, 16'd3, 1'b0, 1'b0);
        checkOutput("ar_c3", 32'(bus.count), 3);
        checkOutput("ar_done", 32'(bus.done), 1);
        applyStimulus(1'b0, 16'd3, 1'b0, 1'b0);
        checkOutput("ar_c2b", 32'(bus.count), 2);
        applyStimulus(1'b0, 16'd3, 1'b0, 1'b1);
        checkOutput("ar_stop_cnt", 32'(bus.count), 2);
        checkOutput("ar_stop_run", 32'(bus.running), 0);
        applyStimulus(1'b0, 16'd3, 1'b0, 1'b0);
        checkOutput("ar_hold", 32'(bus.count), 2);
        applyStimulus(1'b0, 16'd3, 1'b1, 1'b0);
        checkOutput("ar_resume", 32'(bus.count), 1);
        applyStimulus(1'b0, 16'd3, 1'b0, 1'b0);
        checkOutput("ar_wrap", 32'(bus.count), 3);
        checkOutput("ar_done2", 32'(bus.done), 1);
        checkOutput("ar_noexp", 32'(bus.expired), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
